// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the SDF FFT stage controllers.
// Mode encoding matches the stage datapath and twiddle ROM.
package fft_ctrl_pkg;

  localparam logic [1:0] MODE_LOAD = 2'd0;
  localparam logic [1:0] MODE_BFLY = 2'd1;
  localparam logic [1:0] MODE_TWID = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // ROM entry HALF+k holds W^k, so the twiddle region starts at HALF
  function automatic int unsigned twid_base(input int unsigned half);
    return half;
  endfunction

endpackage

// File: rtl/sdf_stage_ctrl.sv
// Sample counter and sequencer for one radix-2 SDF FFT stage.
// Drives butterfly mode and twiddle address; drains on flush.
module sdf_stage_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int HALF = 32,
  parameter int AW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          flush,
  output logic          in_ready,
  output logic [1:0]    bf_mode,
  output logic [AW-1:0] rom_addr,
  output logic          out_valid,
  output logic          out_first,
  output logic          drain,
  output logic          blk_done,
  output logic          ovf
);

  localparam logic [AW-1:0] HALF_A  = AW'(twid_base(HALF));
  localparam logic [AW-1:0] HALF_M1 = AW'(HALF - 1);
  localparam logic [AW-1:0] LAST    = AW'(2 * HALF - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] dcnt_q, dcnt_d;
  logic          pend_q, pend_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] rom_q, rom_d;
  logic          ov_q, ov_d;
  logic          of_q, of_d;
  logic          dr_q, dr_d;
  logic          bd_q, bd_d;
  logic          ovf_q, ovf_d;
  logic          acc;
  logic          fl;

  assign in_ready = (state_q != ST_DRAIN);
  assign acc      = in_valid && in_ready;
  assign fl       = pend_q || flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    rom_d   = rom_q;
    ov_d    = 1'b0;
    of_d    = 1'b0;
    dr_d    = 1'b0;
    bd_d    = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc) begin
          cnt_d   = AW'(1);
          state_d = ST_FILL;
          mode_d  = MODE_LOAD;
          rom_d   = '0;
        end
      end
      ST_FILL: begin
        pend_d = fl;
        if (acc) begin
          mode_d = MODE_LOAD;
          rom_d  = '0;
          cnt_d  = cnt_q + AW'(1);
          if (cnt_q == HALF_M1)
            state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        pend_d = fl;
        if (acc) begin
          ov_d = 1'b1;
          if (cnt_q >= HALF_A) begin
            mode_d = MODE_BFLY;
            rom_d  = '0;
            of_d   = (cnt_q == HALF_A);
          end else begin
            mode_d = MODE_TWID;
            rom_d  = HALF_A + cnt_q;
          end
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == LAST) begin
            bd_d = 1'b1;
            if (fl) begin
              state_d = ST_DRAIN;
              dcnt_d  = '0;
              pend_d  = 1'b0;
            end
          end
        end else if (cnt_q == '0 && fl) begin
          // pending flush at a block boundary with no sample waiting
          state_d = ST_DRAIN;
          dcnt_d  = '0;
          pend_d  = 1'b0;
        end
      end
      ST_DRAIN: begin
        mode_d = MODE_TWID;
        rom_d  = HALF_A + dcnt_q;
        ov_d   = 1'b1;
        dr_d   = 1'b1;
        if (in_valid)
          ovf_d = 1'b1;
        dcnt_d = dcnt_q + AW'(1);
        if (dcnt_q == HALF_M1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      pend_q  <= 1'b0;
      mode_q  <= MODE_LOAD;
      rom_q   <= '0;
      ov_q    <= 1'b0;
      of_q    <= 1'b0;
      dr_q    <= 1'b0;
      bd_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      rom_q   <= rom_d;
      ov_q    <= ov_d;
      of_q    <= of_d;
      dr_q    <= dr_d;
      bd_q    <= bd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bf_mode   = mode_q;
  assign rom_addr  = rom_q;
  assign out_valid = ov_q;
  assign out_first = of_q;
  assign drain     = dr_q;
  assign blk_done  = bd_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: directed scenarios plus random traffic,
// checked against a sample-count model of the stage schedule.
module tb_sdf_stage_ctrl;

  localparam int HALF = 32;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          flush;
  logic          in_ready;
  logic [1:0]    bf_mode;
  logic [AW-1:0] rom_addr;
  logic          out_valid;
  logic          out_first;
  logic          drain;
  logic          blk_done;
  logic          ovf;

  int tests = 0;
  int fails = 0;

  // model: samples accepted since idle, pending flush, drain cycles left
  int n;
  bit pend;
  int dl;
  bit m_ovf;
  int e_mode, e_rom;
  bit e_ov, e_of, e_dr, e_bd;

  sdf_stage_ctrl #(.HALF(HALF), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .in_ready(in_ready), .bf_mode(bf_mode), .rom_addr(rom_addr),
    .out_valid(out_valid), .out_first(out_first), .drain(drain),
    .blk_done(blk_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; pend = 0; dl = 0; m_ovf = 0;
    e_mode = 0; e_rom = 0;
    e_ov = 0; e_of = 0; e_dr = 0; e_bd = 0;
  endtask

  task automatic model_step(input bit v, input bit f, input bit r);
    int k;
    bit fl;
    if (r) begin
      model_reset();
      return;
    end
    e_ov = 0; e_of = 0; e_dr = 0; e_bd = 0;
    if (dl > 0) begin
      e_mode = 2;
      e_rom  = HALF + (HALF - dl);
      e_ov   = 1;
      e_dr   = 1;
      if (v) m_ovf = 1;
      dl--;
      if (dl == 0) n = 0;
      return;
    end
    fl = pend || (f && n > 0);
    if (v) begin
      k = n % (2 * HALF);
      if (n < HALF) begin
        e_mode = 0; e_rom = 0;
      end else if (k >= HALF) begin
        e_mode = 1; e_rom = 0; e_ov = 1;
        e_of = (k == HALF);
      end else begin
        e_mode = 2; e_rom = HALF + k; e_ov = 1;
      end
      n++;
      if (n % (2 * HALF) == 0) begin
        e_bd = 1;
        if (fl) begin dl = HALF; fl = 0; end
      end
      pend = fl;
    end else if (fl && n > 0 && n % (2 * HALF) == 0) begin
      dl = HALF;
      pend = 0;
    end else begin
      pend = fl;
    end
  endtask

  task automatic chk_outs();
    chk("bf_mode", int'(bf_mode), e_mode);
    chk("rom_addr", int'(rom_addr), e_rom);
    chk("out_valid", int'(out_valid), int'(e_ov));
    chk("out_first", int'(out_first), int'(e_of));
    chk("drain", int'(drain), int'(e_dr));
    chk("blk_done", int'(blk_done), int'(e_bd));
    chk("ovf", int'(ovf), int'(m_ovf));
  endtask

  task automatic cyc(input bit v, input bit f, input bit r);
    in_valid = v; flush = f; rst = r;
    if (!r) chk("in_ready", int'(in_ready), int'(dl == 0));
    model_step(v, f, r);
    @(posedge clk);
    #1;
    chk_outs();
  endtask

  task automatic run(input int cnt, input bit v);
    for (int i = 0; i < cnt; i++) cyc(v, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    chk_outs();
    chk("in_ready_rst", int'(in_ready), 1);

    // continuous stream: fill, butterfly, twiddle, two blocks
    run(128, 1'b1);

    // alternating gaps
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 256; i++) cyc(i[0] == 1'b0, 1'b0, 1'b0);

    // flush at sample 40, then drain and restart
    cyc(1'b0, 1'b0, 1'b1);
    run(39, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    run(24, 1'b1);
    chk("drain_entry_ready", int'(in_ready), 0);
    run(32, 1'b0);
    chk("after_drain_ready", int'(in_ready), 1);
    run(3, 1'b1);

    // flush latched early, input held high across drain
    cyc(1'b0, 1'b0, 1'b1);
    run(9, 1'b1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    run(53, 1'b1);
    run(32, 1'b1);
    chk("ovf_sticky", int'(ovf), 1);
    run(40, 1'b1);

    // reset mid-block at sample 50
    cyc(1'b0, 1'b0, 1'b1);
    run(49, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    run(10, 1'b1);

    // random traffic with rare flush and reset
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
          $urandom_range(0, 1999) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdf_stage_ctrl.md
Name: sdf_stage_ctrl

Overview:
Sequencing controller for one radix-2 single-path delay-feedback (SDF) stage of the 1024-point FFT pipeline. It drives the twiddle ROM address and the butterfly mode for the stage whose delay line is HALF samples long. It counts accepted samples and handles input gaps. On a flush request it drains the delay line, so back-to-back and terminated frames stream through one shared butterfly/multiplier datapath.

Parameters:
HALF, 32, delay-line depth of the stage (power of two, 2..512); block length is 2*HALF
AW, 6, log2(2*HALF); width of rom_addr and the internal sample counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  input sample present this cycle
flush  in  1  one-cycle request: finish the current block, then drain the delay line
in_ready  out  1  controller accepts a sample this cycle
bf_mode  out  2  0=LOAD (input into delay, no output), 1=BFLY (output sum, store difference), 2=TWID (output delayed difference times twiddle)
rom_addr  out  AW  twiddle ROM index; HALF+k selects W^k, 0 selects W=1
out_valid  out  1  stage output valid this cycle
out_first  out  1  pulse on the first output of each block
drain  out  1  datapath must use zero input (delay-line drain cycle)
blk_done  out  1  pulse when a 2*HALF-sample block completes at the input
ovf  out  1  sticky: a sample arrived while in_ready=0

Behaviour:
- Reset: everything clears on the clk edge where rst=1, including mid-block. After reset: state=IDLE, cnt=0, flush_pend=0, in_ready=1, bf_mode=0, rom_addr=0, out_valid=0, out_first=0, drain=0, blk_done=0, ovf=0.
- Acceptance: a sample is accepted when in_valid && in_ready.
- Output timing: bf_mode, rom_addr, out_valid, out_first, drain and blk_done are registered. They appear exactly 1 cycle after the acceptance (or drain) cycle they describe, aligned with the datapath input register.
- in_ready is combinational from state: it is 0 only in DRAIN.
- States:
  - IDLE: no history. The first accepted sample sets cnt to 1 and moves to FILL; its mode is LOAD.
  - FILL: first half of the first block. Each accepted sample has mode LOAD, out_valid=0 and rom_addr=0. When the sample with cnt=HALF-1 is accepted, move to RUN.
  - RUN: for an accepted sample with cnt>=HALF, mode is BFLY, out_valid=1 and rom_addr=0. For cnt<HALF, mode is TWID, out_valid=1 and rom_addr=HALF+cnt.
  - out_first=1 for the sample with cnt=HALF.
  - cnt increments modulo 2*HALF on each acceptance. When cnt wraps from 2*HALF-1 to 0, blk_done=1.
  - DRAIN: runs for HALF cycles using internal dcnt 0..HALF-1. Each cycle has mode TWID, out_valid=1, drain=1 and rom_addr=HALF+dcnt. After dcnt=HALF-1, return to IDLE with cnt=0.
- Gaps: when in_valid=0 in IDLE/FILL/RUN, cnt holds and out_valid=0, out_first=0, blk_done=0. bf_mode and rom_addr hold their last value.
- Flush:
  - flush in IDLE is ignored.
  - flush in FILL/RUN sets flush_pend. It takes effect at the next block boundary, i.e. the acceptance that wraps cnt to 0, or immediately if cnt=0 in RUN with no acceptance that cycle. The state becomes DRAIN on the following cycle and flush_pend clears.
  - flush and an accepted sample in the same cycle: the sample is processed normally and the flush is latched.
  - A repeated flush while flush_pend=1 has no extra effect.
  - flush during DRAIN is ignored.
- Overflow: in_valid=1 during DRAIN drops the sample, sets ovf (sticky until rst), and cnt is unchanged.
- Back-to-back blocks: in RUN a wrap goes straight to the next block's TWID phase with no bubble, so out_valid stays continuous under continuous in_valid.

Decomposition:
- Shared package fft_ctrl_pkg holds:
  - mode constants MODE_LOAD=2'd0, MODE_BFLY=2'd1, MODE_TWID=2'd2 (the same encoding the twiddle ROM/stage datapath uses for its state output);
  - the state encoding IDLE/FILL/RUN/DRAIN;
  - a function returning the twiddle base address HALF.
- No sub-module: the counter and FSM are one flat block. Each FFT stage instantiates one controller with its own HALF.

Test Plan:
- Reset, then 64 consecutive in_valid (HALF=32) -> cycles 1-32: mode 0, out_valid=0. Cycle 33: mode 1, out_first=1. Cycles 33-64: mode 1, rom_addr=0. Cycle 64: blk_done=1.
- 128 continuous samples -> samples 65-96: mode 2 with rom_addr 32..63 ascending, out_valid continuous with no bubble. blk_done pulses after samples 64 and 128.
- Every other cycle in_valid=0 -> cnt advances only on accepted samples. Same mode/rom_addr sequence as the continuous case, with out_valid toggling.
- flush at sample 40 of block 1 -> inputs 41-64 accepted normally. Then 32 DRAIN cycles: in_ready=0, drain=1, mode 2, rom_addr 32..63. Then IDLE; the next sample is mode 0.
- in_valid held high during DRAIN -> samples dropped, ovf=1 and stays 1. cnt=0 at the IDLE return.
- rst=1 at sample 50 -> next cycle all outputs are at reset values. A new stream restarts at FILL with mode 0.
